// File: rtl/nsa_pkg.sv
// Shared types and helpers for the nibble-serial adder.
// The overflow flag is built only when NSA_OVF_EN is defined.
package nsa_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Number of nibbles in a WIDTH-bit operand; WIDTH is expected to be a multiple of 4.
  function automatic int nibble_count(input int width);
    return width / NIBBLE_W;
  endfunction

endpackage

// File: rtl/look_ahead_carry_adder.sv
// 4-bit carry-lookahead adder stage: all carries formed directly from generate/propagate terms.
module look_ahead_carry_adder (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);

  logic [3:0] g;
  logic [3:0] p;
  logic [3:0] c;

  always_comb begin
    g = a & b;
    p = a ^ b;
    c[0] = cin;
    c[1] = g[0] | (p[0] & cin);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
    cout = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & cin);
    sum  = p ^ c;
  end

endmodule

// File: rtl/nibble_serial_adder.sv
// Multi-cycle WIDTH-bit adder: one shared 4-bit lookahead stage, LSB nibble first, carry held in a flop.
// Optional signed-overflow output `ovf` is present when NSA_OVF_EN is defined.
module nibble_serial_adder
  import nsa_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
`ifdef NSA_OVF_EN
  output logic             ovf,
`endif
  output state_e           dbg_state
);

  // Handshake: a transfer happens on a rising edge where valid and ready are both high.
  // in_ready/out_valid are pure decodes of the state register, never of in_valid/out_ready.

  localparam int N     = nibble_count(WIDTH);
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [WIDTH-1:0]   sum_q, sum_d;
  logic               carry_q, carry_d;
  logic [IDX_W-1:0]   idx_q, idx_d;

  logic [NIBBLE_W-1:0] stage_a;
  logic [NIBBLE_W-1:0] stage_b;
  logic [NIBBLE_W-1:0] stage_sum;
  logic                stage_cout;

  always_comb begin
    stage_a = a_q[int'(idx_q) * NIBBLE_W +: NIBBLE_W];
    stage_b = b_q[int'(idx_q) * NIBBLE_W +: NIBBLE_W];
  end

  look_ahead_carry_adder u_stage (
    .a   (stage_a),
    .b   (stage_b),
    .cin (carry_q),
    .sum (stage_sum),
    .cout(stage_cout)
  );

`ifdef NSA_OVF_EN
  logic ovf_q, ovf_d;
`endif

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    idx_d   = idx_q;
`ifdef NSA_OVF_EN
    ovf_d   = ovf_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          carry_d = cin;
          idx_d   = '0;
          sum_d   = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        sum_d[int'(idx_q) * NIBBLE_W +: NIBBLE_W] = stage_sum;
        carry_d = stage_cout;
        if (idx_q == LAST_IDX) begin
          state_d = ST_DONE;
`ifdef NSA_OVF_EN
          // The top nibble is being written this cycle, so its MSB comes straight from the stage.
          ovf_d = (a_q[WIDTH-1] == b_q[WIDTH-1]) & (stage_sum[NIBBLE_W-1] != a_q[WIDTH-1]);
`endif
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      idx_q   <= idx_d;
    end
  end

`ifdef NSA_OVF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign ovf = ovf_q;
`endif

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign sum       = sum_q;
  assign cout      = carry_q;
  assign dbg_state = state_q;

endmodule
